// File: rtl/hazard_pkg.sv
// hazard_pkg: shared states, defaults and control vectors for the pipeline hazard controller
package hazard_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_CNT_W = 16;
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_stall;
    logic idex_bubble;
    logic exmem_stall;
  } ctrl_t;
  localparam ctrl_t FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                               idex_stall: 1'b1, idex_bubble: 1'b0, exmem_stall: 1'b1};
  localparam ctrl_t RESET_CTRL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                   idex_stall: 1'b0, idex_bubble: 1'b1, exmem_stall: 1'b0};
  function automatic ctrl_t run_ctrl(input logic lu, input logic br);
    ctrl_t c;
    c = '0;
    c.pc_write = ~lu;
    c.ifid_write = ~lu;
    c.idex_bubble = lu;
    c.ifid_flush = ~lu & br;
    return c;
  endfunction
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: up counter that sticks at all-ones, cleared by async reset
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  // count events until saturation
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_o <= '0;
    else if (inc_i && ~&cnt_o) cnt_o <= cnt_o + W'(1);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, branch-flush and memory-wait pipeline control with perf counters
module hazard_ctrl import hazard_pkg::*; #(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_Rt_i,
  input  logic [4:0]       IFID_Rs_i,
  input  logic [4:0]       IFID_Rt_i,
  input  logic             BranchTaken_i,
  input  logic             MemReq_i,
  input  logic             MemReady_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXStall_o,
  output logic             IDEXBubble_o,
  output logic             EXMEMStall_o,
  output logic             Error_o,
  output logic [CNT_W-1:0] StallCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o
);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t state, state_nxt;
  logic [WW-1:0] wcnt, wcnt_nxt;
  ctrl_t ctrl, ctrl_out;
  logic memwait, loaduse;
  assign memwait = MemReq_i & ~MemReady_i;
  assign loaduse = IDEX_MemRead_i & (IDEX_Rt_i != 5'd0) &
                   ((IDEX_Rt_i == IFID_Rs_i) | (IDEX_Rt_i == IFID_Rt_i));
  // state, wait counter and sticky error registers
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= RUN;
      wcnt <= '0;
      Error_o <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt <= wcnt_nxt;
      Error_o <= state_nxt == ERROR;
    end
  // next state and pipeline controls
  always_comb begin
    ctrl = FREEZE;
    state_nxt = state;
    wcnt_nxt = wcnt;
    case (state)
      RUN:
        if (memwait) begin
          state_nxt = MEM_WAIT;
          wcnt_nxt = WW'(1);
        end else ctrl = run_ctrl(loaduse, BranchTaken_i);
      MEM_WAIT:
        if (MemReady_i) begin
          ctrl = run_ctrl(loaduse, BranchTaken_i);
          state_nxt = RUN;
          wcnt_nxt = '0;
        end else if (wcnt == WW'(TIMEOUT)) state_nxt = ERROR;
        else wcnt_nxt = wcnt + WW'(1);
      default: ;
    endcase
  end
  assign ctrl_out = rst_i ? RESET_CTRL : ctrl;
  assign PCWrite_o = ctrl_out.pc_write;
  assign IFIDWrite_o = ctrl_out.ifid_write;
  assign IFIDFlush_o = ctrl_out.ifid_flush;
  assign IDEXStall_o = ctrl_out.idex_stall;
  assign IDEXBubble_o = ctrl_out.idex_bubble;
  assign EXMEMStall_o = ctrl_out.exmem_stall;
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(~ctrl_out.pc_write), .cnt_o(StallCnt_o)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(ctrl_out.ifid_flush), .cnt_o(FlushCnt_o)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl with TIMEOUT=4, CNT_W=4
module tb_hazard_ctrl;
  localparam logic [5:0] NORM = 6'b110000;
  localparam logic [5:0] LU   = 6'b000010;
  localparam logic [5:0] BR   = 6'b111000;
  localparam logic [5:0] FRZ  = 6'b000101;
  localparam logic [5:0] RSTV = 6'b001010;
  logic clk = 1'b0, rst = 1'b1;
  logic mem_read, branch, mem_req, mem_ready;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic pc_w, ifid_w, ifid_f, idex_s, idex_b, exmem_s, err;
  logic [3:0] stall_cnt, flush_cnt;
  logic [5:0] ctl;
  int checks = 0, errors = 0;
  assign ctl = {pc_w, ifid_w, ifid_f, idex_s, idex_b, exmem_s};
  always #5 clk = ~clk;
  hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .IDEX_MemRead_i(mem_read), .IDEX_Rt_i(idex_rt),
    .IFID_Rs_i(ifid_rs), .IFID_Rt_i(ifid_rt), .BranchTaken_i(branch),
    .MemReq_i(mem_req), .MemReady_i(mem_ready), .PCWrite_o(pc_w), .IFIDWrite_o(ifid_w),
    .IFIDFlush_o(ifid_f), .IDEXStall_o(idex_s), .IDEXBubble_o(idex_b),
    .EXMEMStall_o(exmem_s), .Error_o(err), .StallCnt_o(stall_cnt), .FlushCnt_o(flush_cnt)
  );
  task automatic idle();
    mem_read = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd1; ifid_rt = 5'd2;
    branch = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    idle(); rst = 1'b1; tick(); rst = 1'b0; #1;
  endtask
  task automatic test_reset();
    idle(); rst = 1'b1; tick();
    checks++; if (ctl !== RSTV) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, RSTV); end
    checks++; if ({err, stall_cnt, flush_cnt} !== 9'd0) begin errors++; $display("FAIL reset_regs got %b/%0d/%0d exp 0/0/0", err, stall_cnt, flush_cnt); end
    rst = 1'b0; #1;
    checks++; if (ctl !== NORM) begin errors++; $display("FAIL post_reset_ctl got %b exp %b", ctl, NORM); end
  endtask
  task automatic test_load_use();
    do_reset();
    mem_read = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; #1;
    checks++; if (ctl !== LU) begin errors++; $display("FAIL lu_rs got %b exp %b", ctl, LU); end
    tick(); mem_read = 1'b0; #1;
    checks++; if (ctl !== NORM) begin errors++; $display("FAIL lu_after got %b exp %b", ctl, NORM); end
    checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_stallcnt got %0d exp 1", stall_cnt); end
    mem_read = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7; #1;
    checks++; if (ctl !== LU) begin errors++; $display("FAIL lu_rt got %b exp %b", ctl, LU); end
    tick(); idle(); #1;
    checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL lu_rt_stallcnt got %0d exp 2", stall_cnt); end
  endtask
  task automatic test_zero_reg();
    do_reset();
    mem_read = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; #1;
    checks++; if (ctl !== NORM) begin errors++; $display("FAIL zero_reg got %b exp %b", ctl, NORM); end
    tick(); idle();
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL zero_reg_cnt got %0d exp 0", stall_cnt); end
  endtask
  task automatic test_branch();
    do_reset();
    branch = 1'b1; #1;
    checks++; if (ctl !== BR) begin errors++; $display("FAIL branch got %b exp %b", ctl, BR); end
    tick(); branch = 1'b0; #1;
    checks++; if (ctl !== NORM || flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin errors++; $display("FAIL branch_after ctl %b fc %0d sc %0d exp %b 1 0", ctl, flush_cnt, stall_cnt, NORM); end
    branch = 1'b1; mem_read = 1'b1; idex_rt = 5'd9; ifid_rs = 5'd9; #1;
    checks++; if (ctl !== LU) begin errors++; $display("FAIL branch_lu got %b exp %b", ctl, LU); end
    tick(); idle();
    checks++; if (flush_cnt !== 4'd1 || stall_cnt !== 4'd1) begin errors++; $display("FAIL branch_lu_cnt fc %0d sc %0d exp 1 1", flush_cnt, stall_cnt); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    branch = 1'b1; tick(); tick(); idle(); #1;
    checks++; if (flush_cnt !== 4'd2) begin errors++; $display("FAIL b2b_flush got %0d exp 2", flush_cnt); end
  endtask
  task automatic test_mem_wait();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl !== FRZ) begin errors++; $display("FAIL mw_freeze%0d got %b exp %b", i, ctl, FRZ); end
      tick();
    end
    mem_ready = 1'b1; #1;
    checks++; if (ctl !== NORM) begin errors++; $display("FAIL mw_ready got %b exp %b", ctl, NORM); end
    tick(); mem_ready = 1'b0; #1;
    checks++; if (ctl !== FRZ || stall_cnt !== 4'd3) begin errors++; $display("FAIL mw_back_run ctl %b sc %0d exp %b 3", ctl, stall_cnt, FRZ); end
    mem_req = 1'b0; #1;
    checks++; if (ctl !== NORM) begin errors++; $display("FAIL mw_run got %b exp %b", ctl, NORM); end
  endtask
  task automatic test_mem_loaduse();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0; mem_read = 1'b1; idex_rt = 5'd4; ifid_rt = 5'd4; #1;
    checks++; if (ctl !== FRZ) begin errors++; $display("FAIL mlu_freeze got %b exp %b", ctl, FRZ); end
    tick(); mem_ready = 1'b1; #1;
    checks++; if (ctl !== LU) begin errors++; $display("FAIL mlu_ready got %b exp %b", ctl, LU); end
    tick(); idle(); #1;
    checks++; if (ctl !== NORM || stall_cnt !== 4'd2) begin errors++; $display("FAIL mlu_after ctl %b sc %0d exp %b 2", ctl, stall_cnt, NORM); end
  endtask
  task automatic test_timeout();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (ctl !== FRZ || err !== 1'b0) begin errors++; $display("FAIL to_cycle%0d ctl %b err %b exp %b 0", i, ctl, err, FRZ); end
      tick();
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_error got %b exp 1", err); end
    mem_ready = 1'b1; mem_req = 1'b0; #1;
    checks++; if (ctl !== FRZ) begin errors++; $display("FAIL to_sticky_ctl got %b exp %b", ctl, FRZ); end
    tick();
    checks++; if (err !== 1'b1 || stall_cnt !== 4'd6) begin errors++; $display("FAIL to_sticky err %b sc %0d exp 1 6", err, stall_cnt); end
    rst = 1'b1; #1;
    checks++; if (err !== 1'b0 || stall_cnt !== 4'd0 || ctl !== RSTV) begin errors++; $display("FAIL to_async_rst err %b sc %0d ctl %b exp 0 0 %b", err, stall_cnt, ctl, RSTV); end
    rst = 1'b0; idle(); #1;
    checks++; if (ctl !== NORM) begin errors++; $display("FAIL to_after_rst got %b exp %b", ctl, NORM); end
  endtask
  task automatic test_reset_mid_wait();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0; tick(); tick();
    rst = 1'b1; #1;
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d exp 0", stall_cnt); end
    rst = 1'b0; mem_req = 1'b0; #1;
    checks++; if (ctl !== NORM) begin errors++; $display("FAIL mid_rst_run got %b exp %b", ctl, NORM); end
  endtask
  task automatic test_saturation();
    do_reset();
    mem_read = 1'b1; idex_rt = 5'd6; ifid_rs = 5'd6;
    for (int i = 0; i < 14; i++) tick();
    checks++; if (stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_14 got %0d exp 14", stall_cnt); end
    for (int i = 0; i < 6; i++) tick();
    idle();
    checks++; if (stall_cnt !== 4'd15 || flush_cnt !== 4'd0) begin errors++; $display("FAIL sat_20 sc %0d fc %0d exp 15 0", stall_cnt, flush_cnt); end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    idle();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch();
    test_back_to_back();
    test_mem_wait();
    test_mem_loaduse();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
